// File: rtl/dmem_sized_if.sv
// Request/response bundle between the load/store unit (master) and dmem_sized (slave).
interface dmem_sized_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sized.sv
// Sized data memory for the ARM core: byte/half/word loads and stores with sign control,
// fixed-latency in-order responses, access-error reporting and an optional post-reset clear sweep.
module dmem_sized #(
    parameter int    DEPTH          = 64,
    parameter int    ADDR_W         = 32,
    parameter int    READ_LAT       = 1,
    parameter bit    CLEAR_ON_RESET = 1'b0,
    parameter string INIT_FILE      = "data_mem_init.dat"
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_sized_if.slave bus,
    output logic        busy_o
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_e;

    logic [31:0]       mem [DEPTH];
    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clearCnt_q, clearCnt_d;
    logic              clearWr;
    logic              accept;
    logic              reqErr;
    logic [ADDR_W-3:0] wordIdx;
    logic [IDX_W-1:0]  memIdx;
    logic [1:0]        lane;
    logic [31:0]       rdWord;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic [31:0]       loadData;
    logic [31:0]       wrMask;
    logic [31:0]       wrData;
    logic              s1Valid_q, s1Err_q;
    logic [31:0]       s1Rdata_q;

    assign wordIdx  = bus.req_addr[ADDR_W-1:2];
    assign lane     = bus.req_addr[1:0];
    assign memIdx   = wordIdx[IDX_W-1:0];
    assign accept   = reset_n && bus.req_valid && bus.req_ready;
    assign rdWord   = mem[memIdx];
    assign laneByte = rdWord[{lane, 3'b000} +: 8];
    assign laneHalf = rdWord[{lane[1], 4'b0000} +: 16];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if (CLEAR_ON_RESET) state_q <= CLEAR;
            else                state_q <= RUN;
            clearCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clearCnt_q <= clearCnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        clearCnt_d    = clearCnt_q;
        clearWr       = 1'b0;
        busy_o        = 1'b0;
        bus.req_ready = 1'b0;
        case (state_q)
            CLEAR: begin
                busy_o     = 1'b1;
                clearWr    = reset_n;
                clearCnt_d = clearCnt_q + 1'b1;
                if (clearCnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d    = RUN;
                    clearCnt_d = '0;
                end
            end
            default: bus.req_ready = 1'b1;
        endcase
    end

    // Out-of-range is checked on the full word index so high address bits never alias.
    always_comb begin
        reqErr = 1'b0;
        case (bus.req_size)
            2'b01:   reqErr = lane[0];
            2'b10:   reqErr = (lane != 2'b00);
            2'b11:   reqErr = 1'b1;
            default: reqErr = 1'b0;
        endcase
        if (wordIdx >= (ADDR_W-2)'(DEPTH)) reqErr = 1'b1;
    end

    always_comb begin
        loadData = '0;
        wrMask   = '0;
        wrData   = '0;
        case (bus.req_size)
            2'b00: begin
                loadData = {{24{bus.req_signed & laneByte[7]}}, laneByte};
                wrMask   = 32'h0000_00FF << {lane, 3'b000};
                wrData   = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                loadData = {{16{bus.req_signed & laneHalf[15]}}, laneHalf};
                wrMask   = 32'h0000_FFFF << {lane[1], 4'b0000};
                wrData   = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                loadData = rdWord;
                wrMask   = 32'hFFFF_FFFF;
                wrData   = bus.req_wdata;
            end
            default: begin
                loadData = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clearWr) begin
            mem[clearCnt_q] <= '0;
        end else if (accept && bus.req_we && !reqErr) begin
            mem[memIdx] <= (rdWord & ~wrMask) | (wrData & wrMask);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1Valid_q <= 1'b0;
            s1Err_q   <= 1'b0;
            s1Rdata_q <= '0;
        end else begin
            s1Valid_q <= accept;
            s1Err_q   <= accept && reqErr;
            s1Rdata_q <= (accept && !bus.req_we && !reqErr) ? loadData : '0;
        end
    end

    generate
        if (READ_LAT == 2) begin : gLat2
            logic        s2Valid_q, s2Err_q;
            logic [31:0] s2Rdata_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    s2Valid_q <= 1'b0;
                    s2Err_q   <= 1'b0;
                    s2Rdata_q <= '0;
                end else begin
                    s2Valid_q <= s1Valid_q;
                    s2Err_q   <= s1Err_q;
                    s2Rdata_q <= s1Rdata_q;
                end
            end

            assign bus.rsp_valid = s2Valid_q;
            assign bus.rsp_err   = s2Err_q;
            assign bus.rsp_rdata = s2Rdata_q;
        end else begin : gLat1
            assign bus.rsp_valid = s1Valid_q;
            assign bus.rsp_err   = s1Err_q;
            assign bus.rsp_rdata = s1Rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: three instances (A: 64 words/lat 1, B: 64 words/lat 2,
// C: 16 words/lat 1/clear sweep) checked against a byte-addressed reference memory.
module tb_dmem_sized;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } expEntry_t;

    logic clk = 1'b0;
    logic rstA_n, rstB_n, rstC_n;
    logic busyA, busyB, busyC;
    int   cyc = 0;
    int   compareCount = 0;
    int   mismatchCount = 0;
    int   rspCount[3] = '{0, 0, 0};
    int   lat[3] = '{1, 2, 1};
    int   depth[3] = '{64, 64, 16};
    string names[3] = '{"A", "B", "C"};
    expEntry_t qA[$], qB[$], qC[$];
    logic [7:0] memModel[3][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_sized_if #(.ADDR_W(32)) ifA ();
    dmem_sized_if #(.ADDR_W(32)) ifB ();
    dmem_sized_if #(.ADDR_W(32)) ifC ();

    dmem_sized #(.DEPTH(64), .ADDR_W(32), .READ_LAT(1), .CLEAR_ON_RESET(1'b0), .INIT_FILE(""))
        uDutA (.clk(clk), .reset_n(rstA_n), .bus(ifA), .busy_o(busyA));
    dmem_sized #(.DEPTH(64), .ADDR_W(32), .READ_LAT(2), .CLEAR_ON_RESET(1'b0), .INIT_FILE(""))
        uDutB (.clk(clk), .reset_n(rstB_n), .bus(ifB), .busy_o(busyB));
    dmem_sized #(.DEPTH(16), .ADDR_W(32), .READ_LAT(1), .CLEAR_ON_RESET(1'b1), .INIT_FILE(""))
        uDutC (.clk(clk), .reset_n(rstC_n), .bus(ifC), .busy_o(busyC));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idleAll();
        ifA.req_valid = 1'b0;
        ifB.req_valid = 1'b0;
        ifC.req_valid = 1'b0;
    endtask

    // Reference behaviour: little-endian byte array, so lane n of a word is byte address 4*idx+n.
    task automatic modelAccess(input int k, input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic err, output logic [31:0] rdata);
        int nBytes;
        err = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00)
              || ((addr >> 2) >= 32'(depth[k]));
        rdata = '0;
        if (err) return;
        nBytes = 1 << size;
        for (int i = 0; i < nBytes; i++) begin
            if (we) memModel[k][addr[7:0] + 8'(i)] = wdata[8*i +: 8];
            else    rdata[8*i +: 8] = memModel[k][addr[7:0] + 8'(i)];
        end
        if (!we && sgn && size == 2'b00 && rdata[7])  rdata[31:8]  = '1;
        if (!we && sgn && size == 2'b01 && rdata[15]) rdata[31:16] = '1;
    endtask

    task automatic applyStimulus(input int k, input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        expEntry_t   e;
        logic        expErr;
        logic [31:0] expData;
        @(negedge clk);
        idleAll();
        case (k)
            0: begin
                ifA.req_valid = 1'b1; ifA.req_we = we; ifA.req_size = size;
                ifA.req_signed = sgn; ifA.req_addr = addr; ifA.req_wdata = wdata;
            end
            1: begin
                ifB.req_valid = 1'b1; ifB.req_we = we; ifB.req_size = size;
                ifB.req_signed = sgn; ifB.req_addr = addr; ifB.req_wdata = wdata;
            end
            default: begin
                ifC.req_valid = 1'b1; ifC.req_we = we; ifC.req_size = size;
                ifC.req_signed = sgn; ifC.req_addr = addr; ifC.req_wdata = wdata;
            end
        endcase
        modelAccess(k, we, size, sgn, addr, wdata, expErr, expData);
        e.rdata = expData;
        e.err   = expErr;
        e.cycle = cyc + lat[k];
        case (k)
            0:       qA.push_back(e);
            1:       qB.push_back(e);
            default: qC.push_back(e);
        endcase
    endtask

    task automatic monitorOne(input int k, input logic v, input logic [31:0] rd, input logic er);
        expEntry_t e;
        int        n;
        if (v !== 1'b1) return;
        rspCount[k]++;
        case (k)
            0:       n = qA.size();
            1:       n = qB.size();
            default: n = qC.size();
        endcase
        if (n == 0) begin
            checkOutput({names[k], "_unexpected_rsp"}, 32'd1, 32'd0);
            return;
        end
        case (k)
            0:       e = qA.pop_front();
            1:       e = qB.pop_front();
            default: e = qC.pop_front();
        endcase
        checkOutput({names[k], "_rdata"}, rd, e.rdata);
        checkOutput({names[k], "_err"}, {31'b0, er}, {31'b0, e.err});
        checkOutput({names[k], "_cycle"}, cyc, e.cycle);
    endtask

    always @(negedge clk) begin
        monitorOne(0, ifA.rsp_valid, ifA.rsp_rdata, ifA.rsp_err);
        monitorOne(1, ifB.rsp_valid, ifB.rsp_rdata, ifB.rsp_err);
        monitorOne(2, ifC.rsp_valid, ifC.rsp_rdata, ifC.rsp_err);
    end

    task automatic waitDrain();
        int guard = 0;
        @(negedge clk);
        idleAll();
        #1;
        while ((qA.size() + qB.size() + qC.size()) != 0 && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput("drain_pending", qA.size() + qB.size() + qC.size(), 32'd0);
    endtask

    // Called at the negedge where C's reset is released; counts cycles spent sweeping.
    task automatic waitSweep(output int busyCycles, output int readyWhileBusy);
        busyCycles = 0;
        readyWhileBusy = 0;
        #1;
        while (busyC && busyCycles < 200) begin
            busyCycles++;
            if (ifC.req_ready) readyWhileBusy++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles, readyWhileBusy, seen;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 256; a++) memModel[k][a] = 8'h00;
        rstA_n = 1'b0; rstB_n = 1'b0; rstC_n = 1'b0;
        ifA.req_we = 0; ifA.req_size = 0; ifA.req_signed = 0; ifA.req_addr = 0; ifA.req_wdata = 0;
        ifB.req_we = 0; ifB.req_size = 0; ifB.req_signed = 0; ifB.req_addr = 0; ifB.req_wdata = 0;
        ifC.req_we = 0; ifC.req_size = 0; ifC.req_signed = 0; ifC.req_addr = 0; ifC.req_wdata = 0;
        idleAll();
        repeat (3) @(negedge clk);
        checkOutput("rst_A_valid", {31'b0, ifA.rsp_valid}, 32'd0);
        checkOutput("rst_A_rdata", ifA.rsp_rdata, 32'd0);
        checkOutput("rst_A_err", {31'b0, ifA.rsp_err}, 32'd0);
        checkOutput("rst_B_valid", {31'b0, ifB.rsp_valid}, 32'd0);
        checkOutput("rst_C_valid", {31'b0, ifC.rsp_valid}, 32'd0);
        checkOutput("rst_C_busy", {31'b0, busyC}, 32'd1);
        checkOutput("rst_C_ready", {31'b0, ifC.req_ready}, 32'd0);
        checkOutput("rst_A_busy", {31'b0, busyA}, 32'd0);
        checkOutput("rst_B_busy", {31'b0, busyB}, 32'd0);
        rstA_n = 1'b1; rstB_n = 1'b1; rstC_n = 1'b1;
        waitSweep(busyCycles, readyWhileBusy);
        checkOutput("A_ready_after_rst", {31'b0, ifA.req_ready}, 32'd1);
        checkOutput("C_sweep_cycles", busyCycles, 32'd16);
        checkOutput("C_ready_during_sweep", readyWhileBusy, 32'd0);
        checkOutput("C_ready_after_sweep", {31'b0, ifC.req_ready}, 32'd1);

        // C: cleared contents, range limit at 16 words, then a second sweep wipes fresh stores
        applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        applyStimulus(2, 1'b1, 2'b10, 1'b0, 32'h00, 32'hDEADBEEF);
        applyStimulus(2, 1'b1, 2'b10, 1'b0, 32'h3C, 32'h01234567);
        applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        waitDrain();
        @(negedge clk);
        rstC_n = 1'b0;
        for (int a = 0; a < 256; a++) memModel[2][a] = 8'h00;
        repeat (2) @(negedge clk);
        rstC_n = 1'b1;
        waitSweep(busyCycles, readyWhileBusy);
        checkOutput("C_resweep_cycles", busyCycles, 32'd16);
        applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        applyStimulus(2, 1'b0, 2'b10, 1'b0, 32'h3C, 32'h0);
        waitDrain();

        // A: byte lanes and sign control
        applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344);
        applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h07, 32'h123456A5);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h07, 32'h0);
        applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h07, 32'h0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        // A: halfwords and misalignment
        applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h55667788);
        applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h0A, 32'hABCD8001);
        applyStimulus(0, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h09, 32'h0);
        applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'h09, 32'hFFFFFFFF);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h08, 32'h0);
        applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
        // A: out-of-range must not alias onto word 0; reserved size and misaligned word
        applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h00, 32'h13579BDF);
        applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        applyStimulus(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
        // A: fill the low 32 words, then random traffic including out-of-range addresses
        for (int w = 0; w < 32; w++) applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);
        for (int n = 0; n < 60; n++)
            applyStimulus(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 'h103)), $urandom);
        waitDrain();

        // B: back-to-back loads with two-cycle latency
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA0A0A0A0);
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h44, 32'hB1B1B1B1);
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h48, 32'hC2C2C2C2);
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h4C, 32'hD3D3D3D3);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h48, 32'h0);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h4C, 32'h0);
        applyStimulus(1, 1'b0, 2'b00, 1'b1, 32'h4E, 32'h0);
        waitDrain();

        // B: reset one cycle after accepting a load drops its response but keeps the store
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEBABE);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        idleAll();
        #1;
        rstB_n = 1'b0;
        qB.delete();
        seen = rspCount[1];
        repeat (2) @(negedge clk);
        #1;
        checkOutput("B_dropped_during_rst", rspCount[1] - seen, 32'd0);
        rstB_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("B_dropped_after_rst", rspCount[1] - seen, 32'd0);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        waitDrain();

        checkOutput("rsp_total_A_nonzero", {31'b0, rspCount[0] > 90}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
